// File: rtl/rtc_bus_sched.sv
// Three-requester scheduler for a multiplexed-A/D RTC bus: arbitrates, then
// runs ADDR/GAP/DATA/RECOVER phases of T_PH cycles each.
module rtc_bus_sched #(
  parameter int unsigned T_PH  = 4,
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [23:0] addr,
  input  logic [23:0] wdata,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [3:0]  control,
  output logic        busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] PH_LAST = CW'(T_PH - 1);

  // control = {a_d, cs_n, rd_n, wr_n}
  localparam logic [3:0] CTL_OFF  = 4'b1111;
  localparam logic [3:0] CTL_ADDR = 4'b0010;
  localparam logic [3:0] CTL_WR   = 4'b1010;
  localparam logic [3:0] CTL_RD   = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_DATA,
    S_RECOVER
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      last_idx;
  logic            we_l;
  logic [7:0]      addr_l;
  logic [7:0]      wdata_l;

  logic [2:0][7:0] addr_v;
  logic [2:0][7:0] wdata_v;
  logic [2:0]      elig;
  logic [1:0]      ord0, ord1, ord2;
  logic [1:0]      win_idx;
  logic            win_vld;
  logic [2:0]      win_oh;

  assign addr_v  = addr;
  assign wdata_v = wdata;

  // A requester is not re-granted during its own completion pulse.
  assign elig = req & ~done;

  // Search order: rotated past the last owner for round-robin, else 0,1,2.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    if (RR_EN != 0) begin
      case (last_idx)
        2'd0: begin
          ord0 = 2'd1;
          ord1 = 2'd2;
          ord2 = 2'd0;
        end
        2'd1: begin
          ord0 = 2'd2;
          ord1 = 2'd0;
          ord2 = 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win_vld = 1'b1;
    win_idx = ord0;
    if (elig[ord0]) begin
      win_idx = ord0;
    end else if (elig[ord1]) begin
      win_idx = ord1;
    end else if (elig[ord2]) begin
      win_idx = ord2;
    end else begin
      win_vld = 1'b0;
    end
  end

  assign win_oh = 3'b001 << win_idx;

  // Phase sequencer with registered bus outputs for the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_idx <= 2'd2;
      we_l     <= 1'b0;
      addr_l   <= 8'h00;
      wdata_l  <= 8'h00;
      grant    <= 3'b000;
      done     <= 3'b000;
      rdata    <= 8'h00;
      ad_out   <= 8'h00;
      ad_oe    <= 1'b0;
      control  <= CTL_OFF;
      busy     <= 1'b0;
    end else begin
      done <= 3'b000;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state    <= S_ADDR;
            cnt      <= '0;
            grant    <= win_oh;
            last_idx <= win_idx;
            we_l     <= we[win_idx];
            addr_l   <= addr_v[win_idx];
            wdata_l  <= wdata_v[win_idx];
            control  <= CTL_ADDR;
            ad_oe    <= 1'b1;
            ad_out   <= addr_v[win_idx];
            busy     <= 1'b1;
          end
        end

        S_ADDR: begin
          if (cnt != PH_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt     <= '0;
            state   <= S_GAP;
            control <= CTL_OFF;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
          end
        end

        S_GAP: begin
          if (cnt != PH_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt   <= '0;
            state <= S_DATA;
            if (we_l) begin
              control <= CTL_WR;
              ad_oe   <= 1'b1;
              ad_out  <= wdata_l;
            end else begin
              control <= CTL_RD;
              ad_oe   <= 1'b0;
              ad_out  <= 8'h00;
            end
          end
        end

        S_DATA: begin
          if (cnt != PH_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt   <= '0;
            state <= S_RECOVER;
            if (!we_l) begin
              rdata <= ad_in;
            end
            control <= CTL_OFF;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
          end
        end

        S_RECOVER: begin
          if (cnt != PH_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt   <= '0;
            state <= S_IDLE;
            done  <= grant;
            grant <= 3'b000;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          grant   <= 3'b000;
          control <= CTL_OFF;
          ad_oe   <= 1'b0;
          ad_out  <= 8'h00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Owner index is implied by the latched addr/we; ord2 keeps lint quiet when unused.
  logic unused_ok;
  assign unused_ok = &{1'b0, addr_l, ord2};

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Bench for rtc_bus_sched: three configurations (T_PH=4 RR, T_PH=4 fixed,
// T_PH=1 RR) share stimulus and are compared against a phase-arithmetic model.
module tb_rtc_bus_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic [7:0]  ad_in;

  logic [2:0] grant_0, grant_1, grant_2;
  logic [2:0] done_0, done_1, done_2;
  logic [7:0] rdata_0, rdata_1, rdata_2;
  logic [7:0] ad_out_0, ad_out_1, ad_out_2;
  logic       ad_oe_0, ad_oe_1, ad_oe_2;
  logic [3:0] control_0, control_1, control_2;
  logic       busy_0, busy_1, busy_2;

  always #5 clk = ~clk;

  rtc_bus_sched #(.T_PH(4), .RR_EN(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_0), .done(done_0), .rdata(rdata_0), .ad_in(ad_in),
    .ad_out(ad_out_0), .ad_oe(ad_oe_0), .control(control_0), .busy(busy_0));

  rtc_bus_sched #(.T_PH(4), .RR_EN(0)) u_dut_fp (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_1), .done(done_1), .rdata(rdata_1), .ad_in(ad_in),
    .ad_out(ad_out_1), .ad_oe(ad_oe_1), .control(control_1), .busy(busy_1));

  rtc_bus_sched #(.T_PH(1), .RR_EN(1)) u_dut_t1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .grant(grant_2), .done(done_2), .rdata(rdata_2), .ad_in(ad_in),
    .ad_out(ad_out_2), .ad_oe(ad_oe_2), .control(control_2), .busy(busy_2));

  logic [27:0] obs [3];
  assign obs[0] = {grant_0, done_0, control_0, ad_oe_0, ad_out_0, busy_0, rdata_0};
  assign obs[1] = {grant_1, done_1, control_1, ad_oe_1, ad_out_1, busy_1, rdata_1};
  assign obs[2] = {grant_2, done_2, control_2, ad_oe_2, ad_out_2, busy_2, rdata_2};

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner, cycles elapsed since ADDR began, pending done.
  int         m_own  [3];
  int         m_el   [3];
  int         m_last [3];
  int         m_done [3];
  logic       m_we   [3];
  logic [7:0] m_addr [3];
  logic [7:0] m_wd   [3];
  logic [7:0] m_rd   [3];

  function automatic int tph_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit rr_of(input int k);
    return (k != 1);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int t;
      t = tph_of(k);
      if (reset) begin
        m_own[k] = -1; m_el[k] = 0; m_last[k] = 2; m_done[k] = -1; m_rd[k] = 8'h00;
      end else if (m_own[k] < 0) begin
        int w;
        w = -1;
        for (int j = 0; j < 3; j++) begin
          int i;
          i = rr_of(k) ? (m_last[k] + 1 + j) % 3 : j;
          if (w < 0 && req[i] && m_done[k] != i) w = i;
        end
        m_done[k] = -1;
        if (w >= 0) begin
          m_own[k]  = w;
          m_el[k]   = 0;
          m_last[k] = w;
          m_we[k]   = we[w];
          m_addr[k] = addr[8*w +: 8];
          m_wd[k]   = wdata[8*w +: 8];
        end
      end else begin
        if (!m_we[k] && m_el[k] == 3*t - 1) m_rd[k] = ad_in;
        if (m_el[k] == 4*t - 1) begin
          m_done[k] = m_own[k];
          m_own[k]  = -1;
        end else begin
          m_el[k]++;
        end
      end
    end
  endtask

  function automatic logic [27:0] exp_vec(input int k);
    logic [2:0] g, d;
    logic [3:0] c;
    logic       oe, b;
    logic [7:0] ao;
    g = 3'b000; d = 3'b000; c = 4'b1111; oe = 1'b0; ao = 8'h00; b = 1'b0;
    if (m_done[k] >= 0) d[m_done[k]] = 1'b1;
    if (m_own[k] >= 0) begin
      b = 1'b1;
      g[m_own[k]] = 1'b1;
      case (m_el[k] / tph_of(k))
        0: begin c = 4'b0010; oe = 1'b1; ao = m_addr[k]; end
        2: begin
          if (m_we[k]) begin c = 4'b1010; oe = 1'b1; ao = m_wd[k]; end
          else c = 4'b1001;
        end
        default: ;
      endcase
    end
    return {g, d, c, oe, ao, b, m_rd[k]};
  endfunction

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      for (int k = 0; k < 3; k++) check($sformatf("model_cfg%0d", k), 32'(obs[k]), 32'(exp_vec(k)));
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int e, d0, d2, dn0, dn1, npulse, n0, n1;
    logic [2:0] prev0, prev1, dsum;
    logic [2:0] seq0 [4];
    logic [2:0] seq1 [4];
    logic [2:0] exp_rr [4];

    reset = 1'b1; req = 3'b000; we = 3'b000; addr = 24'h0; wdata = 24'h0; ad_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_cfg%0d", k), 32'(obs[k]), {4'h0, 3'b000, 3'b000, 4'b1111, 1'b0, 8'h00, 1'b0, 8'h00});
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single read by requester 1: latency and captured byte.
    @(negedge clk);
    we = 3'b000; addr = 24'h002100; wdata = 24'h0; ad_in = 8'h37; req = 3'b010;
    @(posedge clk);
    e = 0; d0 = -1; d2 = -1;
    while (e < 60 && (d0 < 0 || d2 < 0)) begin
      @(negedge clk);
      if (e < 4) check("rd_addr_phase", {20'h0, control_0, ad_out_0}, {20'h0, 4'b0010, 8'h21});
      if (d2 < 0 && done_2[1]) begin d2 = e; check("rd_rdata_t1", 32'(rdata_2), 32'h37); end
      if (d0 < 0 && done_0[1]) begin d0 = e; check("rd_rdata_t4", 32'(rdata_0), 32'h37); req = 3'b000; end
      @(posedge clk);
      e++;
    end
    check("rd_latency_t4", d0, 16);
    check("rd_latency_t1", d2, 4);
    req = 3'b000;
    repeat (30) @(posedge clk);

    // Single write by requester 0.
    @(negedge clk);
    we = 3'b001; addr = 24'h0000F0; wdata = 24'h00005A; req = 3'b001;
    @(posedge clk);
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i >= 8 && i < 12)
        check("wr_data_phase", {19'h0, control_0, ad_oe_0, ad_out_0}, {19'h0, 4'b1010, 1'b1, 8'h5A});
      if (done_0[0]) begin npulse++; req = 3'b000; end
      @(posedge clk);
    end
    check("wr_done_pulses", npulse, 1);
    repeat (20) @(posedge clk);

    // All three requesting continuously.
    do_reset();
    @(negedge clk);
    we = 3'b000; req = 3'b111;
    n0 = 0; n1 = 0; prev0 = 3'b000; prev1 = 3'b000;
    for (int i = 0; i < 4; i++) begin seq0[i] = 3'b000; seq1[i] = 3'b000; end
    e = 0;
    while (e < 200 && (n0 < 4 || n1 < 1)) begin
      @(negedge clk);
      if (grant_0 != 3'b000 && grant_0 != prev0 && n0 < 4) begin seq0[n0] = grant_0; n0++; end
      if (grant_1 != 3'b000 && grant_1 != prev1 && n1 < 4) begin seq1[n1] = grant_1; n1++; end
      prev0 = grant_0;
      prev1 = grant_1;
      @(posedge clk);
      e++;
    end
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
    for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), 32'(seq0[i]), 32'(exp_rr[i]));
    check("fixed_first_grant", 32'(seq1[0]), 32'(3'b001));
    @(negedge clk);
    req = 3'b000;
    repeat (40) @(posedge clk);

    // Requester 0 holds req through its done cycle while requester 1 waits.
    do_reset();
    @(negedge clk);
    we = 3'b000; req = 3'b011;
    @(posedge clk);
    e = 0; dn0 = -1; dn1 = -1;
    while (e < 80 && (dn0 < 0 || dn1 < 0)) begin
      @(negedge clk);
      if (dn0 < 0 && done_0[0]) dn0 = e;
      if (dn1 < 0 && done_1[0]) dn1 = e;
      @(posedge clk);
      e++;
    end
    check("hold_done_rr", dn0, 16);
    check("hold_done_fixed", dn1, 16);
    @(negedge clk);
    check("hold_next_rr", 32'(grant_0), 32'(3'b010));
    check("hold_next_fixed", 32'(grant_1), 32'(3'b010));
    req = 3'b000;
    repeat (40) @(posedge clk);

    // Reset during the DATA phase of a write aborts silently.
    do_reset();
    @(negedge clk);
    we = 3'b001; addr = 24'h0000F0; wdata = 24'h00005A; req = 3'b001;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_in_data", {21'h0, control_0, ad_oe_0, 1'b0, 2'b00}, {21'h0, 4'b1010, 1'b1, 1'b0, 2'b00});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", {18'h0, grant_0, done_0, control_0, ad_oe_0, busy_0},
          {18'h0, 3'b000, 3'b000, 4'b1111, 1'b0, 1'b0});
    reset = 1'b0;
    req   = 3'b000;
    dsum  = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dsum |= done_0;
    end
    check("abort_no_done", 32'(dsum), 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
      we    = 3'($urandom_range(0, 7));
      addr  = 24'($urandom);
      wdata = 24'($urandom);
      ad_in = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b000;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
